// File: rtl/muldiv_seq.sv
// Multi-cycle sequencer for 8x8 unsigned multiply and 16/8 unsigned divide.
// All arithmetic is done by driving the shared combinational ALU with shifts and add/subtract steps.
module muldiv_seq #(
  parameter int ITER = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [15:0] operand_a,
  input  logic [7:0]  operand_b,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic [3:0]  flags_out,
  output logic        div_zero,
  output logic [4:0]  alu_op,
  output logic        alu_size,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic        alu_c,
  input  logic [15:0] alu_r,
  input  logic [3:0]  alu_flags
);

  localparam logic [4:0] ALUOP_ADD = 5'd0;
  localparam logic [4:0] ALUOP_SUB = 5'd5;
  localparam logic [4:0] ALUOP_SHL = 5'd12;
  localparam int         FLAG_C    = 1;

  typedef enum logic [2:0] {IDLE, CHECK, SHIFT, STEP, FINISH} state_t;

  state_t      state, state_next;
  logic        op_q;
  logic [15:0] a_q;
  logic [7:0]  b_q;
  logic [15:0] w_q;
  logic [15:0] p_q;
  logic        x_q;
  logic [2:0]  cnt;
  logic        dz_q;

  logic        last_iter;
  logic        div_take;
  logic        div_error;
  logic [15:0] w_step;
  logic [15:0] step_res;
  logic        unused_flags;

  assign last_iter    = (cnt == 3'(ITER - 1));
  assign div_take     = x_q | ~alu_flags[FLAG_C];
  assign div_error    = (b_q == 8'h00) | ~alu_flags[FLAG_C];
  assign w_step       = div_take ? {alu_r[7:0], w_q[7:1], 1'b1} : w_q;
  assign step_res     = op_q ? w_step : alu_r;
  assign unused_flags = ^{alu_flags[3:2], alu_flags[0]};

  assign busy     = (state == CHECK) || (state == SHIFT) || (state == STEP);
  assign done     = (state == FINISH);
  assign div_zero = done & dz_q;
  assign alu_c    = 1'b0;

  // ALU drive and next state both follow directly from the current state.
  always_comb begin
    state_next = state;
    alu_op     = ALUOP_ADD;
    alu_size   = 1'b1;
    alu_a      = 16'h0000;
    alu_b      = 16'h0000;
    case (state)
      IDLE: begin
        if (start) state_next = op ? CHECK : SHIFT;
      end
      CHECK: begin
        alu_op     = ALUOP_SUB;
        alu_size   = 1'b0;
        alu_a      = {8'h00, w_q[15:8]};
        alu_b      = {8'h00, b_q};
        state_next = div_error ? FINISH : SHIFT;
      end
      SHIFT: begin
        alu_op     = ALUOP_SHL;
        alu_a      = op_q ? w_q : p_q;
        state_next = STEP;
      end
      STEP: begin
        if (op_q) begin
          alu_op   = ALUOP_SUB;
          alu_size = 1'b0;
          alu_a    = {8'h00, w_q[15:8]};
          alu_b    = {8'h00, b_q};
        end else begin
          alu_op   = ALUOP_ADD;
          alu_a    = p_q;
          alu_b    = b_q[3'(ITER - 1) - cnt] ? {8'h00, a_q[7:0]} : 16'h0000;
        end
        state_next = last_iter ? FINISH : SHIFT;
      end
      FINISH: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Result and flags are captured on the edge entering FINISH so they hold afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      op_q      <= 1'b0;
      a_q       <= 16'h0000;
      b_q       <= 8'h00;
      w_q       <= 16'h0000;
      p_q       <= 16'h0000;
      x_q       <= 1'b0;
      cnt       <= 3'd0;
      dz_q      <= 1'b0;
      result    <= 16'h0000;
      flags_out <= 4'h0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            op_q <= op;
            a_q  <= operand_a;
            b_q  <= operand_b;
            w_q  <= op ? operand_a : {8'h00, operand_a[7:0]};
            p_q  <= 16'h0000;
            cnt  <= 3'd0;
            dz_q <= 1'b0;
          end
        end
        CHECK: begin
          if (div_error) begin
            result    <= a_q;
            flags_out <= 4'b0100;
            dz_q      <= (b_q == 8'h00);
          end
        end
        SHIFT: begin
          if (op_q) begin
            w_q <= alu_r;
            x_q <= alu_flags[FLAG_C];
          end else begin
            p_q <= alu_r;
          end
        end
        STEP: begin
          cnt <= cnt + 3'd1;
          if (op_q) w_q <= w_step;
          else      p_q <= alu_r;
          if (last_iter) begin
            result    <= step_res;
            flags_out <= {step_res[15], 2'b00, (step_res == 16'h0000)};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: a behavioural ALU drives the datapath and
// every operation is compared with a plain-arithmetic reference model.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        op;
  logic [15:0] operand_a;
  logic [7:0]  operand_b;
  logic        busy, done, div_zero;
  logic [15:0] result;
  logic [3:0]  flags_out;
  logic [4:0]  alu_op;
  logic        alu_size;
  logic [15:0] alu_a, alu_b;
  logic        alu_c;
  logic [15:0] alu_r;
  logic [3:0]  alu_flags;

  int total = 0;
  int bad   = 0;

  muldiv_seq #(.ITER(8)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b),
    .busy(busy), .done(done), .result(result), .flags_out(flags_out),
    .div_zero(div_zero), .alu_op(alu_op), .alu_size(alu_size),
    .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
    .alu_r(alu_r), .alu_flags(alu_flags)
  );

  always #5 clk = ~clk;

  // Shared ALU: ADD/SUB/SHL in 16-bit (size=1) or 8-bit (size=0) mode; C is carry/borrow/shifted-out bit.
  always_comb begin
    logic [16:0] wide;
    logic [8:0]  narrow;
    logic        cy;
    alu_r  = 16'h0000;
    cy     = 1'b0;
    wide   = 17'h0;
    narrow = 9'h0;
    case (alu_op)
      5'd0: begin
        if (alu_size) begin wide = {1'b0, alu_a} + {1'b0, alu_b} + {16'h0, alu_c}; alu_r = wide[15:0]; cy = wide[16]; end
        else begin narrow = {1'b0, alu_a[7:0]} + {1'b0, alu_b[7:0]} + {8'h0, alu_c}; alu_r = {8'h00, narrow[7:0]}; cy = narrow[8]; end
      end
      5'd5: begin
        if (alu_size) begin wide = {1'b0, alu_a} - {1'b0, alu_b}; alu_r = wide[15:0]; cy = wide[16]; end
        else begin narrow = {1'b0, alu_a[7:0]} - {1'b0, alu_b[7:0]}; alu_r = {8'h00, narrow[7:0]}; cy = narrow[8]; end
      end
      5'd12: begin
        if (alu_size) begin alu_r = {alu_a[14:0], 1'b0}; cy = alu_a[15]; end
        else begin alu_r = {8'h00, alu_a[6:0], 1'b0}; cy = alu_a[7]; end
      end
      default: alu_r = 16'h0000;
    endcase
    alu_flags[0] = alu_size ? (alu_r == 16'h0000) : (alu_r[7:0] == 8'h00);
    alu_flags[1] = cy;
    alu_flags[2] = 1'b0;
    alu_flags[3] = alu_size ? alu_r[15] : alu_r[7];
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void ref_model(input logic o, input logic [15:0] a, input logic [7:0] b,
                                    output logic [15:0] r, output logic [3:0] f,
                                    output logic dz, output int lat);
    int q, rem;
    dz = 1'b0;
    if (!o) begin
      r   = 16'(int'(a[7:0]) * int'(b));
      lat = 17;
    end else if (b == 8'h00 || a[15:8] >= b) begin
      r   = a;
      dz  = (b == 8'h00);
      lat = 2;
    end else begin
      q   = int'(a) / int'(b);
      rem = int'(a) % int'(b);
      r   = {rem[7:0], q[7:0]};
      lat = 18;
    end
    if (lat == 2) f = 4'b0100;
    else          f = {r[15], 2'b00, (r == 16'h0000)};
  endfunction

  // One full transaction; optionally pokes start at cycles 3/10 and during done.
  task automatic run_op(input logic o, input logic [15:0] a, input logic [7:0] b,
                        input bit poke_busy, input bit poke_done);
    logic [15:0] er;
    logic [3:0]  ef;
    logic        edz;
    int          elat, cyc, busy_cnt;
    ref_model(o, a, b, er, ef, edz, elat);
    op = o; operand_a = a; operand_b = b; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    busy_cnt = 0;
    while (done !== 1'b1 && cyc < 40) begin
      if (busy === 1'b1) busy_cnt++;
      if (poke_busy && (cyc == 3 || cyc == 10)) begin
        start = 1'b1; op = ~o; operand_a = 16'hA5A5; operand_b = 8'h03;
      end else begin
        start = 1'b0;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    check("done_seen", {31'h0, done}, 32'h1);
    check("latency", cyc, elat);
    check("busy_cycles", busy_cnt, elat - 1);
    check("busy_at_done", {31'h0, busy}, 32'h0);
    check("result", {16'h0, result}, {16'h0, er});
    check("flags_out", {28'h0, flags_out}, {28'h0, ef});
    check("div_zero", {31'h0, div_zero}, {31'h0, edz});
    if (poke_done) begin
      start = 1'b1; op = 1'b0; operand_a = 16'h0003; operand_b = 8'h03;
    end
    tick();
    start = 1'b0;
    check("done_pulse_width", {31'h0, done}, 32'h0);
    check("idle_after_finish", {31'h0, busy}, 32'h0);
    check("result_hold", {16'h0, result}, {16'h0, er});
  endtask

  initial begin
    logic [15:0] ra;
    logic [7:0]  rb;
    logic        ro;
    bit          saw_done;
    reset = 1'b1; start = 1'b0; op = 1'b0; operand_a = 16'h0; operand_b = 8'h0;
    tick(); tick();
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_result", {16'h0, result}, 32'h0);
    check("rst_flags", {28'h0, flags_out}, 32'h0);
    check("rst_div_zero", {31'h0, div_zero}, 32'h0);
    reset = 1'b0;
    tick();

    $display("[TB] directed multiply cases");
    run_op(1'b0, 16'h000C, 8'h0A, 1'b0, 1'b0);
    run_op(1'b0, 16'h00FF, 8'hFF, 1'b0, 1'b0);
    run_op(1'b0, 16'h00AB, 8'h00, 1'b0, 1'b0);
    run_op(1'b0, 16'hFF0C, 8'h0A, 1'b0, 1'b0);

    $display("[TB] directed divide cases");
    run_op(1'b1, 16'h1234, 8'h56, 1'b0, 1'b0);
    run_op(1'b1, 16'h00FF, 8'h01, 1'b0, 1'b0);
    run_op(1'b1, 16'h5600, 8'h56, 1'b0, 1'b0);
    run_op(1'b1, 16'h1234, 8'h00, 1'b0, 1'b0);
    run_op(1'b1, 16'hFEFF, 8'hFF, 1'b0, 1'b0);

    $display("[TB] start ignored while busy and during done, then back-to-back");
    run_op(1'b1, 16'h1234, 8'h56, 1'b1, 1'b1);
    run_op(1'b0, 16'h0007, 8'h09, 1'b0, 1'b0);

    $display("[TB] reset in the middle of a multiply");
    op = 1'b0; operand_a = 16'h00C3; operand_b = 8'h5A; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 7; c++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", {31'h0, busy}, 32'h0);
    check("abort_done", {31'h0, done}, 32'h0);
    check("abort_result", {16'h0, result}, 32'h0);
    check("abort_flags", {28'h0, flags_out}, 32'h0);
    saw_done = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (done === 1'b1) saw_done = 1'b1;
      tick();
    end
    check("abort_no_done", {31'h0, saw_done}, 32'h0);
    run_op(1'b0, 16'h0003, 8'h05, 1'b0, 1'b0);

    $display("[TB] randomized operations");
    for (int n = 0; n < 24; n++) begin
      ro = 1'($urandom_range(0, 1));
      rb = 8'($urandom);
      ra = 16'($urandom);
      if (ro && rb != 8'h00 && $urandom_range(0, 3) != 0)
        ra[15:8] = 8'($urandom_range(0, int'(rb) - 1));
      if ($urandom_range(0, 9) == 0) rb = 8'h00;
      run_op(ro, ra, rb, 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle sequencer that runs the CPU's 8x8 unsigned multiply (MLT) and 16/8 unsigned divide (DIV) on the shared combinational `alu`.
- Uses only ALU shift and add/subtract operations.
- Sits beside the `alu` instance in the CPU core. The microcode stalls on `busy` and writes `result` back on `done`.
- The ALU interface is driven combinationally from the sequencer's state. ALU results are registered internally.

Parameters:
ITER, 8, number of shift/step iterations (equals operand B width)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle request; sampled only in IDLE
op  input  1  0 = MLT, 1 = DIV
operand_a  input  16  MLT: multiplicand in [7:0], [15:8] ignored; DIV: dividend
operand_b  input  8  MLT: multiplier; DIV: divisor
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse; result and flags_out are valid
result  output  16  MLT: product; DIV: {remainder, quotient}
flags_out  output  4  {S,V,C,Z} at bits 3..0
div_zero  output  1  one-cycle pulse coincident with done when a DIV had divisor 0
alu_op  output  5  op driven to `alu`
alu_size  output  1  size driven to `alu`
alu_a  output  16  A operand driven to `alu`
alu_b  output  16  B operand driven to `alu`
alu_c  output  1  carry-in driven to `alu`; always 0
alu_r  input  16  `alu` result
alu_flags  input  4  `alu` flags (Z=0, C=1, V=2, S=3)

Behaviour:
- Reset state:
  - state IDLE, counter 0, working register W = 0.
  - busy=0, done=0, div_zero=0, result=0x0000, flags_out=0.
  - Reset mid-operation aborts the operation; no done pulse is produced.
- Idle ALU drive: in IDLE and FINISH, alu_op=ALUOP_ADD(0), alu_size=1, alu_a=0, alu_b=0.
- States: IDLE, CHECK, SHIFT, STEP, FINISH. A 3-bit iteration counter counts 0..ITER-1.
- IDLE:
  - On start, latch op, operand_a and operand_b.
  - W = {8'h00, operand_a[7:0]} for MLT; W = operand_a for DIV. Counter = 0.
  - Next state: MLT -> SHIFT, DIV -> CHECK.
  - start while busy is ignored.
- MLT, SHIFT: alu_op=ALUOP_SHL(12), size=1, alu_a=P.
  - P is the 16-bit product accumulator, cleared at start.
  - Capture P<=alu_r. Next state STEP.
- MLT, STEP: alu_op=ALUOP_ADD(0), size=1, alu_a=P.
  - alu_b={8'h00, operand_a[7:0]} if multiplier bit [7-counter] is 1, else 0. Fixed latency regardless of data.
  - P<=alu_r. Counter increments.
  - Next state: FINISH after iteration ITER-1, else SHIFT.
- DIV, CHECK: alu_op=ALUOP_SUB(5), size=0, alu_a={8'h00, W[15:8]}, alu_b={8'h00, divisor}.
  - If divisor==0: go to FINISH with error, set div_zero.
  - Else if alu_flags[C]==0 (i.e. W[15:8] >= divisor, quotient overflow): go to FINISH with error.
  - Else go to SHIFT.
- DIV, SHIFT: alu_op=ALUOP_SHL, size=1, alu_a=W.
  - W<=alu_r. Save the shifted-out bit (alu_flags[C]) in register X. Next state STEP.
- DIV, STEP: alu_op=ALUOP_SUB, size=0, alu_a={8'h00, W[15:8]}, alu_b={8'h00, divisor}.
  - If X==1 or alu_flags[C]==0: W[15:8]<=alu_r[7:0] and W[0]<=1.
  - Otherwise W is unchanged (restoring division).
  - Counter increments. Next state: FINISH after iteration ITER-1, else SHIFT.
- FINISH: done=1 for exactly one cycle, busy=0 in this cycle, then return to IDLE.
  - result: P for MLT, W for DIV. Error case: result = original operand_a.
  - flags_out:
    - Normal: Z=(result==0), S=result[15], C=0, V=0.
    - Error: V=1, Z=0, S=0, C=0.
- result and flags_out hold until the next FINISH or reset.
- Latency, counted in cycles from the clock edge that samples start to the cycle in which done is high:
  - MLT: 17.
  - DIV (normal): 18.
  - DIV (error): 2.
- start coincident with done in FINISH is ignored; the next start is accepted in the following IDLE cycle.

Test Plan:
- MLT operand_a=0x000C, operand_b=0x0A -> done 17 cycles after start; result=0x0078; flags_out=0b0000; busy high for 16 cycles.
- MLT 0x00FF x 0xFF -> result=0xFE01, S=1, Z=0. MLT 0x00AB x 0x00 -> result=0x0000, Z=1. Check that operand_a[15:8]=0xFF is ignored.
- DIV 0x1234 / 0x56 -> done after 18 cycles; result=0x1036 (remainder 0x10, quotient 0x36); V=0. DIV 0x00FF / 0x01 -> result=0x00FF.
- DIV 0x5600 / 0x56 (overflow) -> done after 2 cycles; result=0x5600; V=1; div_zero=0. DIV 0x1234 / 0x00 -> result=0x1234, V=1, div_zero pulses with done.
- Reset asserted at cycle 7 of an MLT -> next cycle busy=0, result=0, no done pulse. A new MLT 3x5 afterwards -> result=0x000F.
- start pulses at cycles 3 and 10 of a running DIV -> both ignored; exactly one done. Back-to-back start in the IDLE cycle after done -> accepted.
